wshb_mire_writer: RTL and testbench



---
 rtl/wshb_mire_writer.sv | 201 ++++++++++++++++++++
 tb/tb_wshb_mire_writer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wshb_mire_writer.sv
// ---------------------------------------------------------------------------
// wshb_mire_writer
// Wishbone classic master that fills an HDISP x VDISP frame buffer of 32-bit
// pixels with a generated test pattern ("mire"). The bus is released for one
// cycle after every BURST accepted writes so that another master can be
// interleaved later.
//
// Ports
//   sys_clk      in   system clock
//   sys_rst      in   synchronous active-high reset
//   start        in   pulse, begins one frame fill when idle
//   pattern_sel  in   pattern choice (0 grid, 1 gradient, 2 checker, 3 bars),
//                     latched on an accepted start
//   busy         out  high while writing or pausing
//   done         out  one-cycle pulse after the last pixel is acknowledged
//   err_flag     out  sticky slave-error flag, cleared on accepted start
//   wb_cyc/stb/we out Wishbone controls
//   wb_adr       out  byte address 4*(y*HDISP + x)
//   wb_dat_ms    out  write data {8'h00, R, G, B}
//   wb_sel       out  byte enables (all ones while writing)
//   wb_ack       in   slave acknowledge
//   wb_err       in   slave error (takes precedence over ack, write retried)
// ---------------------------------------------------------------------------
module wshb_mire_writer #(
    parameter int HDISP = 800,
    parameter int VDISP = 480,
    parameter int BURST = 64
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    input  logic [1:0]  pattern_sel,
    output logic        busy,
    output logic        done,
    output logic        err_flag,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [31:0] wb_adr,
    output logic [31:0] wb_dat_ms,
    output logic [3:0]  wb_sel,
    input  logic        wb_ack,
    input  logic        wb_err
);

    localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [BW-1:0]   burst_q, burst_d;
    logic [1:0]      pat_q, pat_d;
    logic            err_q, err_d;
    logic            cyc_q, busy_q, done_q;
    logic [31:0]     adr_q, dat_q;
    logic [31:0]     adr_d, dat_d;
    logic            last_s;
    logic            wr_s;

    // Byte address of pixel (x, y), 32-bit unsigned arithmetic.
    function automatic logic [31:0] addr_f(input logic [31:0] px, input logic [31:0] py);
        addr_f = (py * 32'(HDISP) + px) << 2;
    endfunction

    // Pattern generator: pixel colour {8'h00, R, G, B} for (x, y).
    function automatic logic [31:0] pixel_f(input logic [31:0] px, input logic [31:0] py,
                                            input logic [1:0] sel);
        logic [7:0] sum8;
        logic [2:0] bar;
        sum8 = 8'(px + py);
        bar  = 3'((px * 32'd8) / 32'(HDISP));
        case (sel)
            2'd0:    pixel_f = ((px[3:0] == 4'd0) || (py[3:0] == 4'd0)) ? 32'h00FF_FFFF : 32'h0000_0000;
            2'd1:    pixel_f = {8'h00, px[7:0], py[7:0], sum8};
            2'd2:    pixel_f = (px[5] ^ py[5]) ? 32'h00FF_FFFF : 32'h0000_0000;
            2'd3:    pixel_f = {8'h00, {8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
            default: pixel_f = 32'h0000_0000;
        endcase
    endfunction

    assign last_s = (x_q == XW'(HDISP - 1)) && (y_q == YW'(VDISP - 1));

    // Next-state logic: frame walk, burst accounting and error latch.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        burst_d = burst_q;
        pat_d   = pat_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pat_d   = pattern_sel;
                    x_d     = {XW{1'b0}};
                    y_d     = {YW{1'b0}};
                    burst_d = {BW{1'b0}};
                    err_d   = 1'b0;
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (wb_err) begin
                    // Error wins over ack: keep the same pixel so it is retried.
                    err_d = 1'b1;
                end else if (wb_ack) begin
                    if (last_s) begin
                        x_d     = {XW{1'b0}};
                        y_d     = {YW{1'b0}};
                        burst_d = {BW{1'b0}};
                        state_d = ST_DONE;
                    end else begin
                        if (x_q == XW'(HDISP - 1)) begin
                            x_d = {XW{1'b0}};
                            y_d = y_q + YW'(1);
                        end else begin
                            x_d = x_q + XW'(1);
                        end
                        if (burst_q == BW'(BURST - 1)) begin
                            burst_d = {BW{1'b0}};
                            state_d = ST_PAUSE;
                        end else begin
                            burst_d = burst_q + BW'(1);
                        end
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_PAUSE: state_d = ST_WRITE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output pre-computation: bus fields come from the next state so that
    // they are registered yet valid in the cycle right after each ack.
    always_comb begin
        wr_s  = (state_d == ST_WRITE);
        adr_d = 32'h0000_0000;
        dat_d = 32'h0000_0000;
        if (wr_s) begin
            adr_d = addr_f(32'(x_d), 32'(y_d));
            dat_d = pixel_f(32'(x_d), 32'(y_d), pat_d);
        end else begin
            adr_d = 32'h0000_0000;
            dat_d = 32'h0000_0000;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            x_q     <= {XW{1'b0}};
            y_q     <= {YW{1'b0}};
            burst_q <= {BW{1'b0}};
            pat_q   <= 2'd0;
            err_q   <= 1'b0;
            cyc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            adr_q   <= 32'h0000_0000;
            dat_q   <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            burst_q <= burst_d;
            pat_q   <= pat_d;
            err_q   <= err_d;
            cyc_q   <= wr_s;
            busy_q  <= (state_d == ST_WRITE) || (state_d == ST_PAUSE);
            done_q  <= (state_d == ST_DONE);
            adr_q   <= adr_d;
            dat_q   <= dat_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err_flag  = err_q;
    assign wb_cyc    = cyc_q;
    assign wb_stb    = cyc_q;
    assign wb_we     = cyc_q;
    assign wb_sel    = {4{cyc_q}};
    assign wb_adr    = adr_q;
    assign wb_dat_ms = dat_q;

endmodule

// File: tb/tb_wshb_mire_writer.sv
// ---------------------------------------------------------------------------
// Testbench for wshb_mire_writer on a small 8x4 frame with BURST=4.
// A Wishbone slave model with random ack latency records every accepted
// write into a memory that is compared with an arithmetic pattern model.
// ---------------------------------------------------------------------------
module tb_wshb_mire_writer;

    localparam int H = 8;
    localparam int V = 4;
    localparam int B = 4;
    localparam int P = H * V;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        start;
    logic [1:0]  pattern_sel;
    logic        busy, done, err_flag;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_adr, wb_dat_ms;
    logic [3:0]  wb_sel;
    logic        wb_ack, wb_err;

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] mem [0:P-1];

    // Results of the last frame run
    int r_writes, r_pauses, r_done_cycle, r_busy, r_unstable, r_order_err;
    int r_ctrl_err, r_timeout, r_err_drop, r_done_count;
    logic r_err_at_done, r_err_first, r_busy_at_done, r_cyc_after_rst, r_busy_after_rst;

    wshb_mire_writer #(.HDISP(H), .VDISP(V), .BURST(B)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .start      (start),
        .pattern_sel(pattern_sel),
        .busy       (busy),
        .done       (done),
        .err_flag   (err_flag),
        .wb_cyc     (wb_cyc),
        .wb_stb     (wb_stb),
        .wb_we      (wb_we),
        .wb_adr     (wb_adr),
        .wb_dat_ms  (wb_dat_ms),
        .wb_sel     (wb_sel),
        .wb_ack     (wb_ack),
        .wb_err     (wb_err)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference pattern from plain arithmetic on pixel coordinates
    function automatic logic [31:0] pixel_ref(input int x, input int y, input int sel);
        int bar;
        case (sel)
            0: return ((x % 16 == 0) || (y % 16 == 0)) ? 32'h00FF_FFFF : 32'h0;
            1: return 32'((x % 256) * 65536 + (y % 256) * 256 + ((x + y) % 256));
            2: return (((x / 32) % 2) != ((y / 32) % 2)) ? 32'h00FF_FFFF : 32'h0;
            default: begin
                bar = (x * 8) / H;
                return 32'(((bar / 4) % 2) * 32'hFF0000 + ((bar / 2) % 2) * 32'hFF00 + (bar % 2) * 32'hFF);
            end
        endcase
    endfunction

    // Start one frame and act as the Wishbone slave until done, timeout,
    // or a few cycles after an injected reset.
    task automatic run_frame(input int sel, input int max_dly, input int err_at,
                             input int rst_at, input bit poke_mid);
        int cyc_no, dly, tidx, tail;
        bit waiting, erred, rst_done;
        logic [31:0] h_adr, h_dat;
        r_writes = 0; r_pauses = 0; r_done_cycle = 0; r_busy = 0; r_unstable = 0;
        r_order_err = 0; r_ctrl_err = 0; r_timeout = 0; r_err_drop = 0; r_done_count = 0;
        r_err_at_done = 1'b0; r_err_first = 1'b1; r_busy_at_done = 1'b1;
        r_cyc_after_rst = 1'b1; r_busy_after_rst = 1'b1;
        for (int i = 0; i < P; i++) mem[i] = 32'hDEAD_BEEF;
        cyc_no = 0; dly = 0; tidx = 0; tail = 0;
        waiting = 1'b0; erred = 1'b0; rst_done = 1'b0;
        h_adr = 32'h0; h_dat = 32'h0;
        @(negedge sys_clk);
        start = 1'b1;
        pattern_sel = 2'(sel);
        while (1) begin
            @(negedge sys_clk);
            cyc_no++;
            start = 1'b0; wb_ack = 1'b0; wb_err = 1'b0;
            if (poke_mid && cyc_no == 10) start = 1'b1;
            if (poke_mid && cyc_no >= 10) pattern_sel = 2'(sel) ^ 2'b11;
            if (rst_done) begin
                tail++;
                sys_rst = 1'b0;
                if (tail == 1) begin
                    r_cyc_after_rst = wb_cyc;
                    r_busy_after_rst = busy;
                end
                if (done) r_done_count++;
                if (tail >= 8) break;
                continue;
            end
            if (cyc_no == 1) r_err_first = err_flag;
            if (erred && !err_flag) r_err_drop++;
            if (busy) r_busy++;
            if (done) begin
                r_done_cycle = cyc_no;
                r_err_at_done = err_flag;
                r_busy_at_done = busy;
                r_done_count++;
                break;
            end
            if (cyc_no > 2000) begin
                r_timeout = 1;
                break;
            end
            if (wb_cyc) begin
                if (!(wb_stb && wb_we && wb_sel == 4'hF)) r_ctrl_err++;
                if (waiting) begin
                    if (wb_adr !== h_adr || wb_dat_ms !== h_dat) r_unstable++;
                end else begin
                    h_adr = wb_adr; h_dat = wb_dat_ms;
                    dly = $urandom_range(max_dly, 0);
                    waiting = 1'b1;
                    if (wb_adr !== 32'(tidx * 4)) r_order_err++;
                end
                if (tidx == rst_at) begin
                    sys_rst = 1'b1;
                    rst_done = 1'b1;
                end else if (tidx == err_at && !erred) begin
                    wb_err = 1'b1;
                    wb_ack = 1'b1;
                    erred = 1'b1;
                end else if (dly == 0) begin
                    wb_ack = 1'b1;
                    if (h_adr[31:2] < P) mem[h_adr[31:2]] = h_dat;
                    tidx++;
                    waiting = 1'b0;
                end else begin
                    dly--;
                end
            end else if (busy) begin
                r_pauses++;
            end
        end
        wb_ack = 1'b0; wb_err = 1'b0; start = 1'b0;
        r_writes = tidx;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; start = 1'b0; pattern_sel = 2'd0; wb_ack = 1'b0; wb_err = 1'b0;
        repeat (3) @(negedge sys_clk);
        vectors++;
        if ({busy, done, err_flag, wb_cyc, wb_stb, wb_we} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b exp 000000", {busy, done, err_flag, wb_cyc, wb_stb, wb_we});
        end
        vectors++;
        if (wb_adr !== 32'h0 || wb_dat_ms !== 32'h0 || wb_sel !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_bus got adr %h dat %h sel %h exp zeros", wb_adr, wb_dat_ms, wb_sel);
        end
        sys_rst = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic test_basic();
        run_frame(1, 0, -1, -1, 1'b0);
        vectors++;
        if (r_timeout != 0 || r_writes != P) begin
            miscompares++;
            $display("FAIL basic_writes got %0d (timeout %0d) exp %0d", r_writes, r_timeout, P);
        end
        vectors++;
        if (r_pauses != 7) begin
            miscompares++;
            $display("FAIL basic_pauses got %0d exp 7", r_pauses);
        end
        vectors++;
        if (r_done_cycle != 40) begin
            miscompares++;
            $display("FAIL basic_done_cycle got %0d exp 40", r_done_cycle);
        end
        vectors++;
        if (r_busy != 39 || r_busy_at_done !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_busy got %0d cycles, busy@done %b exp 39, 0", r_busy, r_busy_at_done);
        end
        vectors++;
        if (r_order_err != 0 || r_ctrl_err != 0) begin
            miscompares++;
            $display("FAIL basic_addr_ctrl got order %0d ctrl %0d exp 0 0", r_order_err, r_ctrl_err);
        end
        vectors++;
        if (mem[2 * H + 3] !== 32'h0003_0205) begin
            miscompares++;
            $display("FAIL basic_pixel_3_2 got %h exp 00030205", mem[2 * H + 3]);
        end
        @(negedge sys_clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done_pulse got done %b busy %b exp 0 0", done, busy);
        end
    endtask

    task automatic test_patterns();
        for (int s = 0; s < 4; s++) begin
            run_frame(s, 5, -1, -1, 1'b0);
            vectors++;
            if (r_timeout != 0 || r_unstable != 0 || r_writes != P || r_pauses != 7) begin
                miscompares++;
                $display("FAIL pat%0d_protocol got timeout %0d unstable %0d writes %0d pauses %0d exp 0 0 %0d 7",
                         s, r_timeout, r_unstable, r_writes, r_pauses, P);
            end
            for (int i = 0; i < P; i++) begin
                vectors++;
                if (mem[i] !== pixel_ref(i % H, i / H, s)) begin
                    miscompares++;
                    $display("FAIL pat%0d_pixel[%0d] got %h exp %h", s, i, mem[i], pixel_ref(i % H, i / H, s));
                end
            end
        end
        // Bars: with an 8-pixel line each column is its own bar; x=4 is red
        vectors++;
        if (mem[4] !== 32'h00FF_0000) begin
            miscompares++;
            $display("FAIL bars_x4 got %h exp 00ff0000", mem[4]);
        end
    endtask

    task automatic test_error();
        run_frame(2, 2, 9, -1, 1'b0);
        vectors++;
        if (r_timeout != 0 || r_writes != P || r_order_err != 0) begin
            miscompares++;
            $display("FAIL err_frame got timeout %0d writes %0d order %0d exp 0 %0d 0", r_timeout, r_writes, r_order_err, P);
        end
        vectors++;
        if (r_unstable != 0) begin
            miscompares++;
            $display("FAIL err_retry_same_adr got %0d changes exp 0", r_unstable);
        end
        vectors++;
        if (r_err_drop != 0 || r_err_at_done !== 1'b1) begin
            miscompares++;
            $display("FAIL err_flag_sticky got drops %0d flag@done %b exp 0 1", r_err_drop, r_err_at_done);
        end
        for (int i = 0; i < P; i++) begin
            vectors++;
            if (mem[i] !== pixel_ref(i % H, i / H, 2)) begin
                miscompares++;
                $display("FAIL err_pixel[%0d] got %h exp %h", i, mem[i], pixel_ref(i % H, i / H, 2));
            end
        end
        repeat (3) @(negedge sys_clk);
        vectors++;
        if (err_flag !== 1'b1) begin
            miscompares++;
            $display("FAIL err_flag_idle got %b exp 1", err_flag);
        end
        run_frame(3, 0, -1, -1, 1'b0);
        vectors++;
        if (r_err_first !== 1'b0 || r_err_at_done !== 1'b0) begin
            miscompares++;
            $display("FAIL err_flag_clear got %b/%b exp 0/0", r_err_first, r_err_at_done);
        end
    endtask

    task automatic test_reset_mid();
        run_frame(0, 1, -1, 16, 1'b0);
        vectors++;
        if (r_cyc_after_rst !== 1'b0 || r_busy_after_rst !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_drop got cyc %b busy %b exp 0 0", r_cyc_after_rst, r_busy_after_rst);
        end
        vectors++;
        if (r_done_count != 0 || r_writes != 16) begin
            miscompares++;
            $display("FAIL rst_mid_nodone got done %0d writes %0d exp 0 16", r_done_count, r_writes);
        end
        run_frame(0, 0, -1, -1, 1'b0);
        vectors++;
        if (r_timeout != 0 || r_order_err != 0 || r_writes != P || r_done_cycle != 40) begin
            miscompares++;
            $display("FAIL rst_mid_restart got timeout %0d order %0d writes %0d done@%0d exp 0 0 %0d 40",
                     r_timeout, r_order_err, r_writes, r_done_cycle, P);
        end
    endtask

    task automatic test_start_ignored();
        run_frame(1, 1, -1, -1, 1'b1);
        vectors++;
        if (r_timeout != 0 || r_order_err != 0 || r_writes != P || r_done_count != 1) begin
            miscompares++;
            $display("FAIL busy_start_restart got timeout %0d order %0d writes %0d done %0d exp 0 0 %0d 1",
                     r_timeout, r_order_err, r_writes, r_done_count, P);
        end
        for (int i = 0; i < P; i++) begin
            vectors++;
            if (mem[i] !== pixel_ref(i % H, i / H, 1)) begin
                miscompares++;
                $display("FAIL busy_sel_pixel[%0d] got %h exp %h", i, mem[i], pixel_ref(i % H, i / H, 1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_patterns();
        test_error();
        test_reset_mid();
        test_start_ignored();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
